// File: rtl/hvac_pkg.sv
// Shared types and helpers for the HVAC room thermal model.
// No logic of its own; imported by every file of the block.
// Holds the temperature type, FSM state and heating/cooling direction.
package hvac_pkg;

    typedef logic [7:0] temp_t;

    typedef enum logic [2:0] {
        IDLE,
        SPINUP,
        HEAT,
        COOL,
        FAULT
    } hvac_state_e;

    typedef enum logic {
        DIR_HEAT,
        DIR_COOL
    } dir_e;

    localparam temp_t TEMP_MIN = 8'd0;
    localparam temp_t TEMP_MAX = 8'd255;

    // One degree toward the target; no movement once equal.
    function automatic temp_t step_toward(input temp_t cur, input temp_t target);
        if (cur < target) begin
            return cur + 8'd1;
        end else if (cur > target) begin
            return cur - 8'd1;
        end else begin
            return cur;
        end
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a one-cycle thermal tick every DIV cycles.
// tick is combinational from the count: high while the count equals DIV-1.
// No backpressure; free-running from reset release.
module tick_prescaler #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(DIV - 1));

    // Count 0..DIV-1, wrapping on the tick cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hvac_room_model.sv
// Thermal plant model: fan spin-up, heating/cooling slew, ambient drift, fault.
// temperature/temp_valid update on the edge closing a tick cycle; fault one cycle after heater&aircon.
// No backpressure; commands are level-sampled every cycle.
module hvac_room_model import hvac_pkg::*; #(
    parameter int    TICK_DIV     = 100,
    parameter int    SPINUP_TICKS = 2,
    parameter int    HEAT_TICKS   = 4,
    parameter int    COOL_TICKS   = 4,
    parameter int    DRIFT_TICKS  = 16,
    parameter temp_t INIT_TEMP    = 8'd21
) (
    input  logic  clk,
    input  logic  reset_n,
    input  logic  heater,
    input  logic  aircon,
    input  logic  fan,
    input  temp_t ambient,
    output temp_t temperature,
    output logic  temp_valid,
    output logic  fault
);

    localparam int SW  = $clog2(SPINUP_TICKS) + 1;
    localparam int HW  = $clog2(HEAT_TICKS) + 1;
    localparam int CW  = $clog2(COOL_TICKS) + 1;
    localparam int STW = (HW > CW) ? HW : CW;
    localparam int DW  = $clog2(DRIFT_TICKS) + 1;

    hvac_state_e   state;
    dir_e          dir;
    logic [SW-1:0]  spin_cnt;
    logic [STW-1:0] step_cnt;
    logic [DW-1:0]  drift_cnt;

    logic tick;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // A command without the fan counts as no command at all.
    logic illegal, cmd_heat, cmd_cool, dir_ok;
    assign illegal  = heater & aircon;
    assign cmd_heat = fan & heater & ~aircon;
    assign cmd_cool = fan & aircon & ~heater;
    assign dir_ok   = (dir == DIR_HEAT) ? cmd_heat : cmd_cool;

    logic [SW-1:0]  spin_next;
    logic [STW-1:0] step_next;
    logic [DW-1:0]  drift_next;
    logic spin_done, heat_hit, cool_hit, drift_hit;
    assign spin_next  = spin_cnt + 1'b1;
    assign step_next  = step_cnt + 1'b1;
    assign drift_next = drift_cnt + 1'b1;
    assign spin_done  = (spin_next >= SW'(SPINUP_TICKS));
    assign heat_hit   = (step_next == STW'(HEAT_TICKS));
    assign cool_hit   = (step_next == STW'(COOL_TICKS));
    assign drift_hit  = (drift_next == DW'(DRIFT_TICKS));

    // Saturating +/-1 in 9 bits so the carry/borrow flags the clamp.
    logic [8:0] sum_up, sum_dn;
    temp_t temp_up, temp_dn, temp_drift;
    assign sum_up     = {1'b0, temperature} + 9'd1;
    assign sum_dn     = {1'b0, temperature} - 9'd1;
    assign temp_up    = sum_up[8] ? TEMP_MAX : sum_up[7:0];
    assign temp_dn    = sum_dn[8] ? TEMP_MIN : sum_dn[7:0];
    assign temp_drift = step_toward(temperature, ambient);

    // Plant FSM: fault entry any cycle, everything else on tick cycles only.
    // A tick that changes state clears the counters and moves no temperature.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            dir         <= DIR_HEAT;
            spin_cnt    <= '0;
            step_cnt    <= '0;
            drift_cnt   <= '0;
            temperature <= INIT_TEMP;
            temp_valid  <= 1'b0;
            fault       <= 1'b0;
        end else begin
            temp_valid <= 1'b0;
            if (illegal) begin
                state     <= FAULT;
                fault     <= 1'b1;
                spin_cnt  <= '0;
                step_cnt  <= '0;
                drift_cnt <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (cmd_heat | cmd_cool) begin
                            state     <= SPINUP;
                            dir       <= cmd_heat ? DIR_HEAT : DIR_COOL;
                            // The tick that starts spin-up is its first tick.
                            spin_cnt  <= SW'(1);
                            drift_cnt <= '0;
                        end else if (drift_hit) begin
                            drift_cnt   <= '0;
                            temperature <= temp_drift;
                            temp_valid  <= (temp_drift != temperature);
                        end else begin
                            drift_cnt <= drift_next;
                        end
                    end
                    SPINUP: begin
                        if (!dir_ok) begin
                            state     <= IDLE;
                            spin_cnt  <= '0;
                            drift_cnt <= '0;
                        end else if (spin_done) begin
                            state     <= (dir == DIR_HEAT) ? HEAT : COOL;
                            spin_cnt  <= '0;
                            drift_cnt <= '0;
                            step_cnt  <= '0;
                        end else begin
                            spin_cnt <= spin_next;
                            if (drift_hit) begin
                                drift_cnt   <= '0;
                                temperature <= temp_drift;
                                temp_valid  <= (temp_drift != temperature);
                            end else begin
                                drift_cnt <= drift_next;
                            end
                        end
                    end
                    HEAT: begin
                        if (!cmd_heat) begin
                            state    <= IDLE;
                            step_cnt <= '0;
                        end else if (heat_hit) begin
                            step_cnt    <= '0;
                            temperature <= temp_up;
                            temp_valid  <= (temp_up != temperature);
                        end else begin
                            step_cnt <= step_next;
                        end
                    end
                    COOL: begin
                        if (!cmd_cool) begin
                            state    <= IDLE;
                            step_cnt <= '0;
                        end else if (cool_hit) begin
                            step_cnt    <= '0;
                            temperature <= temp_dn;
                            temp_valid  <= (temp_dn != temperature);
                        end else begin
                            step_cnt <= step_next;
                        end
                    end
                    FAULT: begin
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hvac_room_model.sv
// Bench for hvac_room_model: directed scenarios plus random command segments.
// Every cycle the outputs are compared against a tick-level behavioural plant model.
// Inputs are driven on the falling edge; outputs are sampled on the falling edge.
module tb_hvac_room_model;

    localparam int TD = 4;
    localparam int SP = 2;
    localparam int HT = 2;
    localparam int CT = 2;
    localparam int DT = 8;
    localparam int IT = 21;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       heater = 1'b0;
    logic       aircon = 1'b0;
    logic       fan = 1'b0;
    logic [7:0] ambient = 8'd21;
    logic [7:0] temperature;
    logic       temp_valid;
    logic       fault;

    always #5 clk = ~clk;

    hvac_room_model #(
        .TICK_DIV     (TD),
        .SPINUP_TICKS (SP),
        .HEAT_TICKS   (HT),
        .COOL_TICKS   (CT),
        .DRIFT_TICKS  (DT),
        .INIT_TEMP    (8'(IT))
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .heater      (heater),
        .aircon      (aircon),
        .fan         (fan),
        .ambient     (ambient),
        .temperature (temperature),
        .temp_valid  (temp_valid),
        .fault       (fault)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Plant model: mode plus elapsed ticks since the mode was entered.
    localparam int M_IDLE = 0, M_SPIN = 1, M_HEAT = 2, M_COOL = 3, M_FAULT = 4;
    int m_mode, m_t, m_temp, m_ph;
    bit m_heat_dir, m_valid, m_fault;

    task automatic model_reset();
        m_mode = M_IDLE; m_t = 0; m_temp = IT; m_ph = 0;
        m_heat_dir = 1'b0; m_valid = 1'b0; m_fault = 1'b0;
    endtask

    task automatic model_drift();
        if (m_t % DT == 0) begin
            if (ambient > m_temp) m_temp++;
            else if (ambient < m_temp) m_temp--;
        end
    endtask

    // Advance the model across the next rising edge using the current inputs.
    task automatic model_edge();
        int  old;
        bit  tk, wh, wc;
        old = m_temp;
        tk = (m_ph % TD) == TD - 1;
        m_ph++;
        if (m_mode == M_FAULT) begin
            // frozen until reset
        end else if (heater && aircon) begin
            m_mode = M_FAULT; m_fault = 1'b1;
        end else if (tk) begin
            wh = fan && heater;
            wc = fan && aircon;
            case (m_mode)
                M_IDLE: begin
                    if (wh || wc) begin
                        m_mode = M_SPIN; m_heat_dir = wh; m_t = 0;
                    end else begin
                        m_t++; model_drift();
                    end
                end
                M_SPIN: begin
                    if (!(m_heat_dir ? wh : wc)) begin
                        m_mode = M_IDLE; m_t = 0;
                    end else if (m_t + 2 >= SP) begin
                        // commanded ticks so far = entry tick + m_t + this one
                        m_mode = m_heat_dir ? M_HEAT : M_COOL; m_t = 0;
                    end else begin
                        m_t++; model_drift();
                    end
                end
                M_HEAT: begin
                    if (!wh) begin
                        m_mode = M_IDLE; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t % HT == 0 && m_temp < 255) m_temp++;
                    end
                end
                M_COOL: begin
                    if (!wc) begin
                        m_mode = M_IDLE; m_t = 0;
                    end else begin
                        m_t++;
                        if (m_t % CT == 0 && m_temp > 0) m_temp--;
                    end
                end
                default: ;
            endcase
        end
        m_valid = (m_temp != old);
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        check("temperature", temperature, m_temp);
        check("temp_valid", temp_valid, m_valid);
        check("fault", fault, m_fault);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        heater = 1'b0; aircon = 1'b0; fan = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_temperature", temperature, IT);
        check("rst_temp_valid", temp_valid, 0);
        check("rst_fault", fault, 0);
        reset_n = 1'b1;
    endtask

    int sel, len;

    initial begin
        // Quiet plant at ambient.
        ambient = 8'd21;
        do_reset();
        run(200);
        check("idle_hold", temperature, 21);

        // Heating with fan, then fan drop.
        do_reset();
        heater = 1'b1; fan = 1'b1;
        run(16);
        check("heat_tick4", temperature, 22);
        check("heat_tick4_valid", temp_valid, 1);
        run(8);
        check("heat_tick6", temperature, 23);
        fan = 1'b0;
        run(28);
        check("heat_fan_drop", temperature, 23);
        run(60);

        // Drift toward a cooler ambient, with and without a fanless heater.
        for (int k = 0; k < 2; k++) begin
            do_reset();
            ambient = 8'd15;
            heater = (k == 1);
            run(32);
            check("drift_tick8", temperature, 20);
            run(32);
            check("drift_tick16", temperature, 19);
        end

        // Cool down to the floor, then heat up to the ceiling.
        do_reset();
        ambient = 8'd21;
        aircon = 1'b1; fan = 1'b1;
        run(400);
        check("cool_floor", temperature, 0);
        check("cool_floor_valid", temp_valid, 0);
        do_reset();
        heater = 1'b1; fan = 1'b1;
        run(2000);
        check("heat_ceiling", temperature, 255);
        run(40);

        // Illegal command pulse mid-heat freezes the plant.
        do_reset();
        heater = 1'b1; fan = 1'b1;
        run(24);
        aircon = 1'b1;
        step();
        check("fault_rise", fault, 1);
        aircon = 1'b0;
        for (int i = 0; i < 100; i++) begin
            {heater, aircon, fan} = 3'($urandom_range(0, 7));
            step();
        end
        check("fault_frozen", temperature, 23);
        do_reset();

        // Asynchronous reset in the middle of spin-up.
        heater = 1'b1; fan = 1'b1;
        run(24);
        fan = 1'b0;
        run(4);
        fan = 1'b1;
        run(6);
        #2 reset_n = 1'b0;
        #1;
        check("arst_temperature", temperature, IT);
        check("arst_temp_valid", temp_valid, 0);
        check("arst_fault", fault, 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        run(15);
        check("arst_no_early_heat", temperature, 21);
        run(1);
        check("arst_full_spinup", temperature, 22);

        // Random command segments against the model.
        do_reset();
        for (int s = 0; s < 250; s++) begin
            if ($urandom_range(0, 3) == 0) ambient = 8'($urandom_range(0, 60));
            if ($urandom_range(0, 40) == 0) do_reset();
            sel = $urandom_range(0, 5);
            heater = (sel == 1) || (sel == 3);
            aircon = (sel == 2) || (sel == 4);
            fan    = (sel == 1) || (sel == 2) || (sel == 5);
            if ($urandom_range(0, 60) == 0) begin
                heater = 1'b1; aircon = 1'b1;
                step();
                aircon = 1'b0;
            end
            len = $urandom_range(1, 60);
            run(len);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hvac_room_model.md
# hvac_room_model

Cycle-based thermal plant model closing the loop around the temperature controller. It consumes the `heater`/`aircon`/`fan` commands and produces the 8-bit `temperature` the controller reads back. The model covers fan spin-up delay, heating and cooling slew, drift toward ambient, and illegal-command fault detection. It sits in the HVAC testbench/emulation fabric opposite the controller.

## Interface
- `TICK_DIV`, 100: clock cycles per thermal tick (≥2)
- `SPINUP_TICKS`, 2: ticks of fan-plus-command before heating/cooling takes effect (≥1)
- `HEAT_TICKS`, 4: ticks per +1 degree while heating (≥1)
- `COOL_TICKS`, 4: ticks per −1 degree while cooling (≥1)
- `DRIFT_TICKS`, 16: ticks per 1-degree step toward ambient (≥1)
- `INIT_TEMP`, 8'd21: temperature after reset
- `clk`  in  1  rising-edge clock
- `reset_n`  in  1  asynchronous, active-low reset
- `heater`  in  1  heat command
- `aircon`  in  1  cool command
- `fan`  in  1  fan command
- `ambient`  in  8  ambient temperature, unsigned degrees
- `temperature`  out  8  modelled room temperature, unsigned, registered
- `temp_valid`  out  1  one-cycle pulse in the cycle `temperature` takes a new value
- `fault`  out  1  sticky flag: `heater` and `aircon` were asserted together

## Operation
- Prescaler counts 0..TICK_DIV−1. `tick` is high on the cycle the count equals TICK_DIV−1; the count then wraps to 0.
- States: IDLE, SPINUP, HEAT, COOL, FAULT. Direction register `dir` (heat/cool) is latched on entry to SPINUP.
- FAULT entry: `heater & aircon` in any state on any cycle goes to FAULT on the next edge, regardless of `tick`. FAULT holds `temperature` and sets `fault`=1. Only reset exits FAULT.
- All other transitions are evaluated only on `tick` cycles.
  - IDLE → SPINUP when `fan & (heater ^ aircon)`. `heater` or `aircon` without `fan` is treated as no command.
  - SPINUP counts ticks. It returns to IDLE if the command no longer matches `dir` or `fan` drops. It moves to HEAT/COOL on the tick where the spin-up count reaches SPINUP_TICKS.
  - HEAT/COOL → IDLE when `fan` drops or the matching command drops. HEAT ↔ COOL always passes through IDLE.
- HEAT: step counter advances per tick. When it reaches HEAT_TICKS: `temperature`+1, counter cleared. Saturates at 255.
- COOL: same as HEAT using COOL_TICKS, −1 per step. Saturates at 0.
- Drift is active in IDLE and SPINUP only. Drift counter advances per tick. When it reaches DRIFT_TICKS: step 1 toward `ambient` (no step if equal), counter cleared.
- Step and drift counters clear on every state change.
- `temp_valid` pulses only when the value actually changes. A saturated or equal-to-ambient step produces no pulse.
- Counter widths are `$clog2` of their parameter + 1. Temperature arithmetic is 9-bit internally, clamped to 0..255.

## Timing
- Reset (asynchronous assert, synchronous release): `temperature`=INIT_TEMP, `temp_valid`=0, `fault`=0, state IDLE, all counters 0.
- Reset mid-operation discards all state immediately.
- State and `temperature` update on the tick edge. The new value is visible in the cycle after the tick cycle, with `temp_valid` high in that same cycle.
- Heating latency from command assertion is (SPINUP_TICKS+HEAT_TICKS) ticks ±1 tick, depending on the prescaler phase.
- `fault` rises one cycle after the illegal combination is sampled.

## Structure
- Package `hvac_pkg` holds:
  - `temp_t` (logic [7:0])
  - `hvac_state_e` (IDLE, SPINUP, HEAT, COOL, FAULT)
  - `TEMP_MIN`/`TEMP_MAX` constants
  - `dir_e`
- One sub-module, `tick_prescaler` (parameter DIV; outputs `tick`). Everything else lives in `hvac_room_model`.

## Test plan
All scenarios use TICK_DIV=4, SPINUP_TICKS=2, HEAT_TICKS=2, COOL_TICKS=2, DRIFT_TICKS=8, INIT_TEMP=21.
- Reset, ambient=21, no commands for 200 cycles → `temperature`=21 throughout, `temp_valid` never pulses, `fault`=0.
- `heater`=`fan`=1 from cycle 0 → 22 after tick 4, 23 after tick 6, one `temp_valid` pulse per step. Drop `fan` at tick 7 → IDLE, no further increase.
- ambient=15, no commands → 20 after tick 8, 19 after tick 16. `heater`=1 with `fan`=0 gives the identical result.
- `aircon`=`fan`=1 with INIT_TEMP overridden to 1 → 0 after tick 4, then stays 0 with no further `temp_valid`. With INIT_TEMP=254 and heating → 255, then holds.
- `heater`=`aircon`=1 for one cycle mid-HEAT → `fault`=1 next cycle, `temperature` frozen for 100 cycles despite commands. Reset clears it to 21 and `fault`=0.
- Assert `reset_n`=0 asynchronously mid-SPINUP → outputs return to reset values within the same cycle. After release, a full SPINUP_TICKS is required before the first heating step.
